// File: rtl/act_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_pkg : mode encodings and width/bound helpers for activation requant  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package act_pkg;

   typedef enum logic [1:0] {
      MODE_RELU  = 2'd0,
      MODE_CLIP  = 2'd1,
      MODE_LEAKY = 2'd2,
      MODE_PASS  = 2'd3
   } act_mode_e;

   localparam int C_OVF_W = 16;

   // One guard bit keeps the rounding add from overflowing.
   function automatic int rnd_width(input int accw);
      return accw + 1;
   endfunction

   function automatic longint umax_of(input int w);
      return (64'sd1 <<< w) - 64'sd1;
   endfunction

   function automatic longint smax_of(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint smin_of(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_lane : one channel -- round/shift stage, then activate and saturate  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module act_lane
   import act_pkg::*;
#(
   parameter int DATAW = 8,
   parameter int ACCW  = 32,
   parameter int SHW   = 5
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   ld_s1,
   input  logic                   ld_s2,
   input  logic signed [ACCW-1:0] acc,
   input  logic [SHW-1:0]         shift,
   input  act_mode_e              mode,
   input  logic [DATAW-1:0]       clip,
   input  logic [2:0]             leak,
   output logic [DATAW-1:0]       data,
   output logic                   sat
);

   localparam int YW = rnd_width(ACCW);

   localparam logic signed [YW-1:0] c_umax = YW'(umax_of(DATAW));
   localparam logic signed [YW-1:0] c_smax = YW'(smax_of(DATAW));
   localparam logic signed [YW-1:0] c_smin = YW'(smin_of(DATAW));

   logic signed [YW-1:0] w_ext;
   logic signed [YW-1:0] w_half;
   logic signed [YW-1:0] w_sum;
   logic signed [YW-1:0] w_y;
   logic signed [YW-1:0] r_y;
   logic signed [YW-1:0] w_clip_ext;
   logic signed [YW-1:0] w_pre;
   logic [DATAW-1:0]     w_res;
   logic                 w_sat;

   always_comb begin
      w_ext  = {acc[ACCW-1], acc};
      w_half = '0;
      if (shift != '0) begin
         w_half = {{(YW-1){1'b0}}, 1'b1} << (shift - 1'b1);
      end
      w_sum = w_ext + w_half;
      w_y   = w_sum >>> shift;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_y <= '0;
      end else if (ld_s1) begin
         r_y <= w_y;
      end
   end

   assign w_clip_ext = {{(YW-DATAW){1'b0}}, clip};

   // ReLU zeroing of negatives is not a saturation event; only upper clamps are.
   always_comb begin
      w_pre = r_y;
      w_res = '0;
      w_sat = 1'b0;
      case (mode)
         MODE_RELU: begin
            if (r_y[YW-1]) begin
               w_res = '0;
            end else if (r_y > c_umax) begin
               w_res = c_umax[DATAW-1:0];
               w_sat = 1'b1;
            end else begin
               w_res = r_y[DATAW-1:0];
            end
         end
         MODE_CLIP: begin
            if (r_y[YW-1]) begin
               w_res = '0;
            end else if (r_y > w_clip_ext) begin
               w_res = clip;
               w_sat = 1'b1;
            end else begin
               w_res = r_y[DATAW-1:0];
            end
         end
         MODE_LEAKY, MODE_PASS: begin
            w_pre = (mode == MODE_LEAKY && r_y[YW-1]) ? (r_y >>> leak) : r_y;
            if (w_pre > c_smax) begin
               w_res = c_smax[DATAW-1:0];
               w_sat = 1'b1;
            end else if (w_pre < c_smin) begin
               w_res = c_smin[DATAW-1:0];
               w_sat = 1'b1;
            end else begin
               w_res = w_pre[DATAW-1:0];
            end
         end
         default: begin
            w_res = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         data <= '0;
         sat  <= 1'b0;
      end else if (ld_s2) begin
         data <= w_res;
         sat  <= w_sat;
      end
   end

endmodule
`default_nettype wire

// File: rtl/act_requant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_requant : two-stage multi-lane requantiser with saturation counter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module act_requant
   import act_pkg::*;
#(
   parameter int DATAW = 8,
   parameter int ACCW  = 32,
   parameter int LANES = 4,
   parameter int SHW   = 5
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [LANES*ACCW-1:0]    in_data,
   input  logic [1:0]               cfg_mode,
   input  logic [SHW-1:0]           cfg_shift,
   input  logic [DATAW-1:0]         cfg_clip,
   input  logic [2:0]               cfg_leak,
   input  logic                     cnt_clr,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [LANES*DATAW-1:0]   out_data,
   output logic [C_OVF_W-1:0]       ovf_cnt
);

   logic             w_en;
   logic             w_ld_s1;
   logic             w_ld_s2;
   logic             w_xfer_out;
   logic [LANES-1:0] w_sat;

   logic             r_s1_vld;
   act_mode_e        r_s1_mode;
   logic [DATAW-1:0] r_s1_clip;
   logic [2:0]       r_s1_leak;
   logic             r_out_vld;
   logic [C_OVF_W-1:0] r_ovf_cnt;

   // Whole pipeline moves together whenever the output slot is free or draining.
   assign w_en       = !r_out_vld || out_rdy;
   assign in_rdy     = w_en;
   assign w_ld_s1    = w_en && in_vld;
   assign w_ld_s2    = w_en && r_s1_vld;
   assign w_xfer_out = r_out_vld && out_rdy;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_s1_vld  <= 1'b0;
         r_out_vld <= 1'b0;
      end else if (w_en) begin
         r_s1_vld  <= in_vld;
         r_out_vld <= r_s1_vld;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_s1_mode <= MODE_RELU;
         r_s1_clip <= '0;
         r_s1_leak <= '0;
      end else if (w_ld_s1) begin
         r_s1_mode <= act_mode_e'(cfg_mode);
         r_s1_clip <= cfg_clip;
         r_s1_leak <= cfg_leak;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         act_lane #(
            .DATAW (DATAW),
            .ACCW  (ACCW),
            .SHW   (SHW)
         ) u_lane (
            .clk   (clk),
            .rst_b (rst_b),
            .ld_s1 (w_ld_s1),
            .ld_s2 (w_ld_s2),
            .acc   (in_data[i*ACCW +: ACCW]),
            .shift (cfg_shift),
            .mode  (r_s1_mode),
            .clip  (r_s1_clip),
            .leak  (r_s1_leak),
            .data  (out_data[i*DATAW +: DATAW]),
            .sat   (w_sat[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_ovf_cnt <= '0;
      end else if (cnt_clr) begin
         r_ovf_cnt <= '0;
      end else if (w_xfer_out && (|w_sat) && (r_ovf_cnt != {C_OVF_W{1'b1}})) begin
         r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
   end

   assign out_vld = r_out_vld;
   assign ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_act_requant.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_act_requant : directed self-checking bench for act_requant            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_act_requant;

   localparam int DATAW = 8;
   localparam int ACCW  = 32;
   localparam int LANES = 4;
   localparam int SHW   = 5;

   logic                   clk = 1'b0;
   logic                   rst_b;
   logic                   in_vld;
   logic                   in_rdy;
   logic [LANES*ACCW-1:0]  in_data;
   logic [1:0]             cfg_mode;
   logic [SHW-1:0]         cfg_shift;
   logic [DATAW-1:0]       cfg_clip;
   logic [2:0]             cfg_leak;
   logic                   cnt_clr;
   logic                   out_vld;
   logic                   out_rdy;
   logic [LANES*DATAW-1:0] out_data;
   logic [15:0]            ovf_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int sent;
   int recv;
   int cyc;

   act_requant #(
      .DATAW (DATAW),
      .ACCW  (ACCW),
      .LANES (LANES),
      .SHW   (SHW)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .cfg_mode  (cfg_mode),
      .cfg_shift (cfg_shift),
      .cfg_clip  (cfg_clip),
      .cfg_leak  (cfg_leak),
      .cnt_clr   (cnt_clr),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pack_in(input int a0, input int a1, input int a2, input int a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [31:0] pack_out(input int b0, input int b1, input int b2, input int b3);
      return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
   endfunction

   task automatic set_cfg(input int mode, input int shift, input int clip, input int leak);
      cfg_mode  = mode[1:0];
      cfg_shift = shift[4:0];
      cfg_clip  = clip[7:0];
      cfg_leak  = leak[2:0];
   endtask

   // Entered at 1ns after a rising edge; cfg is scrambled right after acceptance.
   task automatic run_beat(input string tag, input int mode, input int shift, input int clip,
                           input int leak, input logic [127:0] din, input logic [31:0] exp_d,
                           input int exp_ovf);
      set_cfg(mode, shift, clip, leak);
      in_data = din;
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      #1;
      chk({tag, "/in_rdy"}, {63'd0, in_rdy}, 64'd1);
      @(posedge clk); #1;
      in_vld  = 1'b0;
      in_data = '0;
      set_cfg(3 - mode, 7, 255 - clip, 7 - leak);
      chk({tag, "/vld_s1"}, {63'd0, out_vld}, 64'd0);
      @(posedge clk); #1;
      chk({tag, "/vld"}, {63'd0, out_vld}, 64'd1);
      chk({tag, "/data"}, {32'd0, out_data}, {32'd0, exp_d});
      @(posedge clk); #1;
      chk({tag, "/vld_done"}, {63'd0, out_vld}, 64'd0);
      chk({tag, "/hold"}, {32'd0, out_data}, {32'd0, exp_d});
      chk({tag, "/ovf"}, {48'd0, ovf_cnt}, 64'(exp_ovf));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b   = 1'b0;
      in_vld  = 1'b0;
      in_data = '0;
      out_rdy = 1'b0;
      cnt_clr = 1'b0;
      set_cfg(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst/out_vld", {63'd0, out_vld}, 64'd0);
      chk("rst/ovf", {48'd0, ovf_cnt}, 64'd0);
      chk("rst/data", {32'd0, out_data}, 64'd0);
      chk("rst/in_rdy", {63'd0, in_rdy}, 64'd1);
      rst_b = 1'b1;

      run_beat("relu_s0", 0, 0, 0, 0, pack_in(-5, 100, 300, 0), pack_out(0, 100, 255, 0), 1);
      run_beat("relu_s4", 0, 4, 0, 0, pack_in(24, 23, -24, 7), pack_out(2, 1, 0, 0), 1);
      run_beat("clip6", 1, 0, 6, 0, pack_in(10, 3, 6, -1), pack_out(6, 3, 6, 0), 2);
      run_beat("leaky3", 2, 0, 0, 3, pack_in(-80, -2000, 200, 5), pack_out(246, 128, 127, 5), 3);
      run_beat("pass_s1", 3, 1, 0, 0, pack_in(-257, 255, -3, 3), pack_out(128, 127, 255, 2), 4);
      run_beat("pass_s2", 3, 2, 0, 0, pack_in(2, -2, 6, -6), pack_out(1, 0, 2, 255), 4);
      run_beat("pass_s31", 3, 31, 0, 0, pack_in(32'h7FFF_FFFF, 32'h8000_0000, 0, 1),
               pack_out(1, 255, 0, 0), 4);

      // Back-to-back stream with a three-cycle downstream stall.
      set_cfg(3, 0, 0, 0);
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 8 && cyc < 40) begin
         out_rdy = !(cyc >= 4 && cyc <= 6);
         in_vld  = (sent < 8);
         in_data = pack_in(sent * 4, sent * 4 + 1, sent * 4 + 2, sent * 4 + 3);
         #1;
         if (cyc >= 4 && cyc <= 6) chk("stream/in_rdy_stall", {63'd0, in_rdy}, 64'd0);
         if (out_vld) chk("stream/data", {32'd0, out_data},
                          {32'd0, pack_out(recv * 4, recv * 4 + 1, recv * 4 + 2, recv * 4 + 3)});
         if (out_vld && out_rdy) recv++;
         if (in_vld && in_rdy) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      chk("stream/recv", 64'(recv), 64'd8);
      chk("stream/sent", 64'(sent), 64'd8);
      chk("stream/no_dup0", {63'd0, out_vld}, 64'd0);
      @(posedge clk); #1;
      chk("stream/no_dup1", {63'd0, out_vld}, 64'd0);
      chk("stream/ovf", {48'd0, ovf_cnt}, 64'd4);

      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr/ovf", {48'd0, ovf_cnt}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         run_beat("sat5", 0, 0, 0, 0, pack_in(300, 0, 0, 0), pack_out(255, 0, 0, 0), i + 1);
      end

      // Reset with two beats in flight.
      set_cfg(3, 0, 0, 0);
      out_rdy = 1'b1;
      in_vld  = 1'b1;
      in_data = pack_in(1, 2, 3, 4);
      @(posedge clk); #1;
      in_data = pack_in(5, 6, 7, 8);
      @(posedge clk); #1;
      in_vld = 1'b0;
      chk("inflight/vld", {63'd0, out_vld}, 64'd1);
      chk("inflight/ovf", {48'd0, ovf_cnt}, 64'd5);
      rst_b = 1'b0;
      #1;
      chk("async_rst/vld", {63'd0, out_vld}, 64'd0);
      chk("async_rst/ovf", {48'd0, ovf_cnt}, 64'd0);
      chk("async_rst/data", {32'd0, out_data}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post_rst/no_stale", {63'd0, out_vld}, 64'd0);
      end

      // Clear coinciding with a saturating output transfer.
      run_beat("pre_clr", 1, 0, 6, 0, pack_in(10, 0, 0, 0), pack_out(6, 0, 0, 0), 1);
      set_cfg(1, 0, 6, 0);
      in_data = pack_in(10, 0, 0, 0);
      in_vld  = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      @(posedge clk); #1;
      chk("clr_race/vld", {63'd0, out_vld}, 64'd1);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr_race/ovf", {48'd0, ovf_cnt}, 64'd0);

      // Long saturating stream; counter must stick at all-ones.
      set_cfg(0, 0, 0, 0);
      in_data = pack_in(1000, 0, 0, 0);
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      in_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sticky/ovf", {48'd0, ovf_cnt}, 64'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
